// File: rtl/cpu_host_pkg.sv
// cpu_host_pkg: shared state encoding, FIFO entry layout and widths for cpu_host
package cpu_host_pkg;
  localparam int ENTRY_W = 16;
  typedef enum logic [2:0] {IDLE, SETUP, HOLD, SAMPLE, GAP, DONE} state_t;
  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] res;
  } entry_t;
endpackage

// File: rtl/cpu_host_if.sv
// cpu_host_if: index/handshake/result link between the host initiator and the cpu
interface cpu_host_if;
  logic [7:0] index;
  logic       handshake;
  logic [7:0] result;
  modport master (output index, output handshake, input result);
  modport slave (input index, input handshake, output result);
endinterface

// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through FIFO with wrapping pointers and an occupancy count
module result_fifo
  import cpu_host_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic do_push, do_pop;
  assign empty = occ == '0;
  assign full = occ == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap at their natural width; occupancy tracks push minus pop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/cpu_host.sv
// cpu_host: steps index through a run, pulses handshake per index and queues {index, result}
module cpu_host
  import cpu_host_pkg::*;
#(
  parameter int HOLD_CYCLES = 150,
  parameter int GAP_CYCLES = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  first_index,
  input  logic [7:0]  count,
  cpu_host_if.master  cpu,
  output logic        busy,
  output logic        done,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [15:0] fifo_data,
  input  logic        rd_en
);
  state_t st, nxt;
  logic [7:0] idx, rem;
  logic [15:0] cnt;
  logic hold_done, gap_done, parked;
  entry_t ent;
  assign parked = st == IDLE || st == DONE;
  assign hold_done = cnt == 16'(HOLD_CYCLES - 1);
  assign gap_done = cnt >= 16'(GAP_CYCLES - 1);
  assign busy = !parked;
  assign done = st == DONE;
  assign cpu.index = idx;
  assign cpu.handshake = st == HOLD || st == SAMPLE;
  assign ent.idx = idx;
  assign ent.res = cpu.result;
  // next-state: a finished gap stalls while the FIFO is full so a push never overflows it
  always_comb begin
    nxt = st;
    case (st)
      IDLE, DONE: if (start) nxt = (count != 8'd0) ? SETUP : DONE;
      SETUP:      nxt = HOLD;
      HOLD:       if (hold_done) nxt = SAMPLE;
      SAMPLE:     nxt = GAP;
      GAP:        if (gap_done) nxt = (rem == 8'd0) ? DONE : fifo_full ? GAP : SETUP;
      default:    nxt = IDLE;
    endcase
  end
  // state, window counter (cleared on every state change, saturating in a stalled gap), index and remaining count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      idx <= 8'h00;
      rem <= 8'h00;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= (nxt != st) ? '0 : (st == GAP && gap_done) ? cnt : cnt + 1'b1;
      if (parked && start && count != 8'd0) begin
        idx <= first_index;
        rem <= count;
      end
      if (st == GAP && nxt == SETUP) idx <= idx + 8'd1;
      if (st == SAMPLE) rem <= rem - 8'd1;
    end
  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (st == SAMPLE),
    .pop   (rd_en),
    .din   (ent),
    .dout  (fifo_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: tb/tb_cpu_host.sv
// tb_cpu_host: table-driven runs plus corner sequences, results checked against a scoreboard queue
module tb_cpu_host;
  logic clk, reset, start, rd_en;
  logic [7:0] first_index, count;
  logic busy, done, fifo_empty, fifo_full;
  logic [15:0] fifo_data;
  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];
  cpu_host_if bus();
  assign bus.result = bus.handshake ? bus.index + 8'h10 : 8'h00;
  cpu_host #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_index (first_index),
    .count       (count),
    .cpu         (bus.master),
    .busy        (busy),
    .done        (done),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_data   (fifo_data),
    .rd_en       (rd_en)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct {
    logic [7:0] fi;
    logic [7:0] cnt;
    int         pulses;
    int         inj;
  } vec_t;
  vec_t vecs [5];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_start(logic [7:0] fi, logic [7:0] c, bit track);
    @(negedge clk);
    first_index = fi;
    count = c;
    start = 1;
    if (track) for (int i = 0; i < int'(c); i++) sb.push_back({8'(fi + i), 8'(fi + i + 16)});
    @(negedge clk);
    start = 0;
  endtask
  task automatic run(logic [7:0] fi, int exp_pulses, int inj, string tag);
    int cyc = 0, hs_hi = 0, pulses = 0, last_rise = -1;
    bit prev = 0;
    while (!(done && fifo_empty) && cyc < 400) begin
      if (bus.handshake && !prev) begin
        check({tag, "_idx"}, bus.index, 8'(fi + pulses));
        if (last_rise >= 0) check({tag, "_period"}, cyc - last_rise, 8);
        last_rise = cyc;
        pulses++;
      end
      if (bus.handshake) hs_hi++;
      prev = bus.handshake;
      if (!fifo_empty && sb.size() > 0) begin
        check({tag, "_data"}, fifo_data, sb.pop_front());
        rd_en = 1;
      end else rd_en = 0;
      start = cyc == inj;
      if (start) begin
        first_index = 8'h99;
        count = 8'd7;
      end
      @(negedge clk);
      cyc++;
    end
    rd_en = 0;
    start = 0;
    check({tag, "_in_time"}, cyc < 400, 1);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_hs_cycles"}, hs_hi, exp_pulses * 5);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask
  initial begin
    int n;
    bit saw;
    vecs[0] = '{8'h02, 8'd1, 1, -1};
    vecs[1] = '{8'hFE, 8'd3, 3, -1};
    vecs[2] = '{8'h40, 8'd0, 0, -1};
    vecs[3] = '{8'h50, 8'd2, 2, 3};
    vecs[4] = '{8'hFF, 8'd1, 1, -1};
    reset = 1;
    start = 0;
    rd_en = 0;
    first_index = 0;
    count = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_index", bus.index, 8'h00);
    check("rst_hs", bus.handshake, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_data", fifo_data, 16'h0000);
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].fi, vecs[v].cnt, 1);
      if (vecs[v].cnt != 0) begin
        check($sformatf("v%0d_setup_busy", v), busy, 1);
        check($sformatf("v%0d_setup_hs", v), bus.handshake, 0);
        check($sformatf("v%0d_setup_idx", v), bus.index, vecs[v].fi);
      end else check($sformatf("v%0d_zero_done", v), done, 1);
      run(vecs[v].fi, vecs[v].pulses, vecs[v].inj, $sformatf("v%0d", v));
    end
    do_start(8'h20, 8'd6, 1);
    n = 0;
    while (!fifo_full && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_full", fifo_full, 1);
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      saw |= bus.handshake;
    end
    check("bp_stall_hs", saw, 0);
    check("bp_stall_busy", busy, 1);
    check("bp_stall_idx", bus.index, 8'h23);
    check("bp_head", fifo_data, sb.pop_front());
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    check("bp_not_full", fifo_full, 0);
    @(negedge clk);
    check("bp_resume_idx", bus.index, 8'h24);
    check("bp_resume_setup", bus.handshake, 0);
    @(negedge clk);
    check("bp_resume_hs", bus.handshake, 1);
    run(8'h24, 2, -1, "bp");
    do_start(8'h30, 8'd2, 0);
    n = 0;
    while (!(!fifo_empty && bus.handshake) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rh_reached", !fifo_empty && bus.handshake, 1);
    #2 reset = 1;
    #1;
    check("rh_hs", bus.handshake, 0);
    check("rh_empty", fifo_empty, 1);
    check("rh_busy", busy, 0);
    check("rh_idx", bus.index, 8'h00);
    check("rh_data", fifo_data, 16'h0000);
    @(negedge clk);
    reset = 0;
    check("rh_done", done, 0);
    do_start(8'h31, 8'd1, 1);
    run(8'h31, 1, -1, "rh_rerun");
    do_start(8'h60, 8'd2, 1);
    n = 0;
    while (!(!fifo_empty && bus.handshake) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("pp_sample_hs", bus.handshake, 1);
    check("pp_head_old", fifo_data, sb.pop_front());
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    check("pp_not_empty", fifo_empty, 0);
    check("pp_not_full", fifo_full, 0);
    check("pp_head_new", fifo_data, sb.pop_front());
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    check("pp_one_left", fifo_empty, 1);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pp_done", done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
